// File: rtl/sdram_arbiter_if.sv
// Requester, SDRAM-controller and status signals of the SDRAM arbiter.
// The arbiter uses the slave modport; the requesters and controller use master.
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16
);
    logic                  io_cpu_cmd_valid;
    logic                  io_cpu_cmd_ready;
    logic                  io_cpu_cmd_write;
    logic [ADDR_WIDTH-1:0] io_cpu_cmd_address;
    logic [DATA_WIDTH-1:0] io_cpu_cmd_data;
    logic                  io_cpu_rsp_valid;
    logic [DATA_WIDTH-1:0] io_cpu_rsp_data;

    logic                  io_vga_cmd_valid;
    logic                  io_vga_cmd_ready;
    logic                  io_vga_cmd_write;
    logic [ADDR_WIDTH-1:0] io_vga_cmd_address;
    logic [DATA_WIDTH-1:0] io_vga_cmd_data;
    logic                  io_vga_rsp_valid;
    logic [DATA_WIDTH-1:0] io_vga_rsp_data;

    logic                  io_mem_cmd_valid;
    logic                  io_mem_cmd_ready;
    logic                  io_mem_cmd_refresh;
    logic                  io_mem_cmd_write;
    logic [ADDR_WIDTH-1:0] io_mem_cmd_address;
    logic [DATA_WIDTH-1:0] io_mem_cmd_data;
    logic                  io_mem_rsp_valid;
    logic [DATA_WIDTH-1:0] io_mem_rsp_data;

    logic                  io_refreshOverrun;

    modport slave (
        input  io_cpu_cmd_valid, io_cpu_cmd_write, io_cpu_cmd_address, io_cpu_cmd_data,
        output io_cpu_cmd_ready, io_cpu_rsp_valid, io_cpu_rsp_data,
        input  io_vga_cmd_valid, io_vga_cmd_write, io_vga_cmd_address, io_vga_cmd_data,
        output io_vga_cmd_ready, io_vga_rsp_valid, io_vga_rsp_data,
        output io_mem_cmd_valid, io_mem_cmd_refresh, io_mem_cmd_write,
        output io_mem_cmd_address, io_mem_cmd_data,
        input  io_mem_cmd_ready, io_mem_rsp_valid, io_mem_rsp_data,
        output io_refreshOverrun
    );

    modport master (
        output io_cpu_cmd_valid, io_cpu_cmd_write, io_cpu_cmd_address, io_cpu_cmd_data,
        input  io_cpu_cmd_ready, io_cpu_rsp_valid, io_cpu_rsp_data,
        output io_vga_cmd_valid, io_vga_cmd_write, io_vga_cmd_address, io_vga_cmd_data,
        input  io_vga_cmd_ready, io_vga_rsp_valid, io_vga_rsp_data,
        input  io_mem_cmd_valid, io_mem_cmd_refresh, io_mem_cmd_write,
        input  io_mem_cmd_address, io_mem_cmd_data,
        output io_mem_cmd_ready, io_mem_rsp_valid, io_mem_rsp_data,
        input  io_refreshOverrun
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port (cpu/vga) SDRAM command arbiter with periodic auto-refresh and in-order read routing.
// Define SDRAM_ARBITER_VGA_PRIO_EN for fixed vga-over-cpu priority instead of round-robin.
//
// state   | meaning
// IDLE    | arbitrate: pending refresh first, else grant one eligible port
// CMD     | presenting a captured port command until the controller accepts it
// REFRESH | presenting an auto-refresh command until the controller accepts it
module sdram_arbiter #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int REFRESH_CYCLES = 781,
    parameter int PENDING_DEPTH  = 4
) (
    input  logic           io_axiClk,
    input  logic           io_asyncReset,
    sdram_arbiter_if.slave bus
);
    localparam int PW = (PENDING_DEPTH > 1) ? $clog2(PENDING_DEPTH) : 1;
    localparam int CW = $clog2(PENDING_DEPTH + 1);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(PENDING_DEPTH);
    localparam logic [RW-1:0] RELOAD  = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CMD, REFRESH} state_t;

    state_t                state, state_nxt;
    logic                  refresh_pending;
    logic                  refresh_overrun;
    logic [RW-1:0]         refresh_cnt;
    logic                  fifo_mem [PENDING_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_cnt;
    logic                  cmd_refresh, cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_address;
    logic [DATA_WIDTH-1:0] cmd_data;

    logic cpu_elig, vga_elig, grant_cpu, grant_vga;
    logic in_idle, load_refresh, push, pop;

`ifndef SDRAM_ARBITER_VGA_PRIO_EN
    logic last_vga;
`endif

    // Reads are only admitted while the source FIFO has room; writes never need it.
    always_comb begin
        cpu_elig     = bus.io_cpu_cmd_valid && (bus.io_cpu_cmd_write || (fifo_cnt < DEPTH_C));
        vga_elig     = bus.io_vga_cmd_valid && (bus.io_vga_cmd_write || (fifo_cnt < DEPTH_C));
        in_idle      = (state == IDLE) && !io_asyncReset;
        load_refresh = in_idle && refresh_pending;
        grant_cpu    = 1'b0;
        grant_vga    = 1'b0;
        if (in_idle && !refresh_pending) begin
`ifdef SDRAM_ARBITER_VGA_PRIO_EN
            if (vga_elig) grant_vga = 1'b1;
            else          grant_cpu = cpu_elig;
`else
            if (cpu_elig && vga_elig) begin
                grant_cpu = last_vga;
                grant_vga = !last_vga;
            end else begin
                grant_cpu = cpu_elig;
                grant_vga = vga_elig;
            end
`endif
        end
        push = (grant_cpu && !bus.io_cpu_cmd_write) || (grant_vga && !bus.io_vga_cmd_write);
        pop  = bus.io_mem_rsp_valid && (fifo_cnt != '0);
    end

    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (refresh_pending)             state_nxt = REFRESH;
                else if (grant_cpu || grant_vga) state_nxt = CMD;
            end
            CMD, REFRESH: begin
                if (bus.io_mem_cmd_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.io_cpu_cmd_ready   = grant_cpu;
        bus.io_vga_cmd_ready   = grant_vga;
        bus.io_mem_cmd_valid   = (state == CMD) || (state == REFRESH);
        bus.io_mem_cmd_refresh = cmd_refresh;
        bus.io_mem_cmd_write   = cmd_write;
        bus.io_mem_cmd_address = cmd_address;
        bus.io_mem_cmd_data    = cmd_data;
        bus.io_cpu_rsp_valid   = pop && !fifo_mem[rd_ptr];
        bus.io_vga_rsp_valid   = pop && fifo_mem[rd_ptr];
        bus.io_cpu_rsp_data    = bus.io_mem_rsp_data;
        bus.io_vga_rsp_data    = bus.io_mem_rsp_data;
        bus.io_refreshOverrun  = refresh_overrun;
    end

    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            cmd_refresh <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_address <= '0;
            cmd_data    <= '0;
        end else if (load_refresh) begin
            cmd_refresh <= 1'b1;
            cmd_write   <= 1'b0;
            cmd_address <= '0;
            cmd_data    <= '0;
        end else if (grant_cpu) begin
            cmd_refresh <= 1'b0;
            cmd_write   <= bus.io_cpu_cmd_write;
            cmd_address <= bus.io_cpu_cmd_address;
            cmd_data    <= bus.io_cpu_cmd_data;
        end else if (grant_vga) begin
            cmd_refresh <= 1'b0;
            cmd_write   <= bus.io_vga_cmd_write;
            cmd_address <= bus.io_vga_cmd_address;
            cmd_data    <= bus.io_vga_cmd_data;
        end
    end

`ifndef SDRAM_ARBITER_VGA_PRIO_EN
    // Reset to vga so that cpu wins the first tie.
    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset)  last_vga <= 1'b1;
        else if (grant_cpu) last_vga <= 1'b0;
        else if (grant_vga) last_vga <= 1'b1;
    end
`endif

    always_ff @(posedge io_axiClk) begin
        if (push) fifo_mem[wr_ptr] <= grant_vga;
    end

    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // A deadline arriving while the previous refresh is still unserved is an overrun.
    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            refresh_cnt     <= RELOAD;
            refresh_pending <= 1'b0;
            refresh_overrun <= 1'b0;
        end else if (refresh_cnt == '0) begin
            refresh_cnt     <= RELOAD;
            refresh_pending <= 1'b1;
            if (refresh_pending) refresh_overrun <= 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt - RW'(1);
            if (load_refresh) refresh_pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table for arbitration/FIFO behaviour,
// scoreboard for command payloads and response routing, hand sequences for refresh and reset.
module tb_sdram_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rbus ();

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_CYCLES(781), .PENDING_DEPTH(4))
        dut (.io_axiClk(clk), .io_asyncReset(rst), .bus(bus));
    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_CYCLES(8), .PENDING_DEPTH(4))
        dut_ref (.io_axiClk(clk), .io_asyncReset(rst), .bus(rbus));

    typedef struct {
        bit          r;
        bit          cv, cw, vv, vw, mr, rv;
        logic [15:0] rd;
        logic [4:0]  e;   // {cpu_ready, vga_ready, mem_valid, cpu_rsp_valid, vga_rsp_valid}
    } vec_t;

    typedef struct packed {
        logic          refresh;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    vec_t vecs[$];
    cmd_t cmd_q[$];
    bit   src_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(bit r, bit cv, bit cw, bit vv, bit vw, bit mr, bit rv,
                                logic [15:0] rd, logic [4:0] e);
        vec_t v;
        v.r = r; v.cv = cv; v.cw = cw; v.vv = vv; v.vw = vw;
        v.mr = mr; v.rv = rv; v.rd = rd; v.e = e;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_q.delete();
        src_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic settle();
        #4;
    endtask

    // Scoreboard: grants push expected commands/sources, handshakes and responses pop them.
    task automatic observe();
        cmd_t e;
        bit   s;
        if (bus.io_cpu_cmd_ready) begin
            cmd_q.push_back({1'b0, bus.io_cpu_cmd_write, bus.io_cpu_cmd_address, bus.io_cpu_cmd_data});
            if (!bus.io_cpu_cmd_write) src_q.push_back(1'b0);
        end
        if (bus.io_vga_cmd_ready) begin
            cmd_q.push_back({1'b0, bus.io_vga_cmd_write, bus.io_vga_cmd_address, bus.io_vga_cmd_data});
            if (!bus.io_vga_cmd_write) src_q.push_back(1'b1);
        end
        if (bus.io_mem_cmd_valid && bus.io_mem_cmd_ready) begin
            if (cmd_q.size() == 0) check("mem_cmd_extra", 64'd1, 64'd0);
            else begin
                e = cmd_q.pop_front();
                check("mem_cmd", {bus.io_mem_cmd_refresh, bus.io_mem_cmd_write,
                                  bus.io_mem_cmd_address, bus.io_mem_cmd_data}, e);
            end
        end
        if (bus.io_mem_rsp_valid) begin
            if (src_q.size() == 0) begin
                check("rsp_drop", {bus.io_cpu_rsp_valid, bus.io_vga_rsp_valid}, 2'b00);
            end else begin
                s = src_q.pop_front();
                check("rsp_route", {bus.io_cpu_rsp_valid, bus.io_vga_rsp_valid}, s ? 2'b01 : 2'b10);
                check("rsp_data", s ? bus.io_vga_rsp_data : bus.io_cpu_rsp_data, bus.io_mem_rsp_data);
            end
        end
    endtask

    task automatic tick();
        observe();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int last_k;
        int n_ref;

        bus.io_cpu_cmd_valid = 0; bus.io_cpu_cmd_write = 0;
        bus.io_cpu_cmd_address = '0; bus.io_cpu_cmd_data = '0;
        bus.io_vga_cmd_valid = 0; bus.io_vga_cmd_write = 0;
        bus.io_vga_cmd_address = '0; bus.io_vga_cmd_data = '0;
        bus.io_mem_cmd_ready = 0; bus.io_mem_rsp_valid = 0; bus.io_mem_rsp_data = '0;
        rbus.io_cpu_cmd_valid = 0; rbus.io_cpu_cmd_write = 0;
        rbus.io_cpu_cmd_address = '0; rbus.io_cpu_cmd_data = '0;
        rbus.io_vga_cmd_valid = 0; rbus.io_vga_cmd_write = 0;
        rbus.io_vga_cmd_address = '0; rbus.io_vga_cmd_data = '0;
        rbus.io_mem_cmd_ready = 1; rbus.io_mem_rsp_valid = 0; rbus.io_mem_rsp_data = '0;

        // Both ports reading continuously, then responses, then a stalled write.
`ifdef SDRAM_ARBITER_VGA_PRIO_EN
        vecs.push_back(mk(1, 1,0, 1,0, 1, 0, 16'h0000, 5'b01000));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b01000));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b01000));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 0,0, 0,0, 1, 1, 16'hA5A5, 5'b00001));
        vecs.push_back(mk(0, 0,0, 0,0, 1, 1, 16'h5A5A, 5'b00001));
        vecs.push_back(mk(0, 0,0, 0,0, 1, 1, 16'h1234, 5'b00001));
`else
        vecs.push_back(mk(1, 1,0, 1,0, 1, 0, 16'h0000, 5'b10000));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b01000));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b10000));
        vecs.push_back(mk(0, 1,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 0,0, 0,0, 1, 1, 16'hA5A5, 5'b00010));
        vecs.push_back(mk(0, 0,0, 0,0, 1, 1, 16'h5A5A, 5'b00001));
        vecs.push_back(mk(0, 0,0, 0,0, 1, 1, 16'h1234, 5'b00010));
`endif
        vecs.push_back(mk(0, 0,0, 0,0, 1, 1, 16'h7777, 5'b00000));
        vecs.push_back(mk(0, 1,1, 0,0, 0, 0, 16'h0000, 5'b10000));
        vecs.push_back(mk(0, 1,1, 0,0, 0, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 1,1, 0,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 1,1, 1,0, 1, 0, 16'h0000, 5'b01000));
        vecs.push_back(mk(0, 0,0, 0,0, 1, 0, 16'h0000, 5'b00100));
        // Four vga reads fill the FIFO; a cpu write still passes; one response frees one slot.
        vecs.push_back(mk(1, 0,0, 1,0, 1, 0, 16'h0000, 5'b01000));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(0, 0,0, 1,0, 1, 0, 16'h0000, 5'b00100));
            vecs.push_back(mk(0, 0,0, 1,0, 1, 0, 16'h0000, 5'b01000));
        end
        vecs.push_back(mk(0, 0,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 1,1, 1,0, 1, 0, 16'h0000, 5'b10000));
        vecs.push_back(mk(0, 0,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 0,0, 1,0, 1, 1, 16'hBEEF, 5'b00001));
        vecs.push_back(mk(0, 0,0, 1,0, 1, 0, 16'h0000, 5'b01000));
        vecs.push_back(mk(0, 0,0, 1,0, 1, 0, 16'h0000, 5'b00100));
        vecs.push_back(mk(0, 0,0, 1,0, 1, 0, 16'h0000, 5'b00000));

        do_reset();
        settle();
        check("reset_state", {bus.io_mem_cmd_valid, bus.io_mem_cmd_refresh, bus.io_mem_cmd_write,
                              bus.io_mem_cmd_address, bus.io_mem_cmd_data, bus.io_refreshOverrun,
                              bus.io_cpu_cmd_ready, bus.io_vga_cmd_ready}, '0);
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].r) do_reset();
            bus.io_cpu_cmd_valid   = vecs[i].cv;
            bus.io_cpu_cmd_write   = vecs[i].cw;
            bus.io_cpu_cmd_address = 24'h000010;
            bus.io_cpu_cmd_data    = 16'(32'hC000 + i);
            bus.io_vga_cmd_valid   = vecs[i].vv;
            bus.io_vga_cmd_write   = vecs[i].vw;
            bus.io_vga_cmd_address = 24'h000020;
            bus.io_vga_cmd_data    = 16'(32'hD000 + i);
            bus.io_mem_cmd_ready   = vecs[i].mr;
            bus.io_mem_rsp_valid   = vecs[i].rv;
            bus.io_mem_rsp_data    = vecs[i].rd;
            settle();
            check($sformatf("vec%0d", i), {bus.io_cpu_cmd_ready, bus.io_vga_cmd_ready,
                  bus.io_mem_cmd_valid, bus.io_cpu_rsp_valid, bus.io_vga_rsp_valid}, vecs[i].e);
            tick();
        end

        // Reset while a command is in flight with two reads pending.
        do_reset();
        bus.io_cpu_cmd_valid = 1; bus.io_cpu_cmd_write = 0;
        bus.io_vga_cmd_valid = 1; bus.io_vga_cmd_write = 0;
        bus.io_mem_cmd_ready = 1; bus.io_mem_rsp_valid = 0;
        settle(); check("mid_grant_cpu", bus.io_cpu_cmd_ready, 1); tick();
        settle(); tick();
        settle(); check("mid_grant_vga", bus.io_vga_cmd_ready, 1); tick();
        bus.io_cpu_cmd_valid = 0; bus.io_vga_cmd_valid = 0; bus.io_mem_cmd_ready = 0;
        settle(); check("mid_in_cmd", bus.io_mem_cmd_valid, 1);
        bus.io_cpu_cmd_valid = 1;
        rst = 1'b1;
        #1;
        check("rst_mem_valid", bus.io_mem_cmd_valid, 0);
        check("rst_cmd_ready", bus.io_cpu_cmd_ready, 0);
        cmd_q.delete();
        src_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.io_cpu_cmd_valid = 0; bus.io_mem_cmd_ready = 1;
        for (int k = 0; k < 3; k++) begin
            settle(); check("post_rst_idle", bus.io_mem_cmd_valid, 0); tick();
        end
        bus.io_mem_rsp_valid = 1; bus.io_mem_rsp_data = 16'h4242;
        settle(); check("post_rst_rsp", {bus.io_cpu_rsp_valid, bus.io_vga_rsp_valid}, 2'b00); tick();
        bus.io_mem_rsp_valid = 0;

        // Refresh cadence with an 8-cycle period, then a stalled controller.
        do_reset();
        rbus.io_mem_cmd_ready = 1;
        last_k = -1;
        n_ref  = 0;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (rbus.io_mem_cmd_valid && rbus.io_mem_cmd_refresh) begin
                if (n_ref == 0) check("ref_first", 64'(k), 64'd9);
                else            check("ref_period", 64'(k - last_k), 64'd8);
                check("ref_payload", {rbus.io_mem_cmd_write, rbus.io_mem_cmd_address,
                                      rbus.io_mem_cmd_data}, '0);
                last_k = k;
                n_ref++;
            end
            tick();
        end
        check("ref_count", 64'(n_ref), 64'd4);
        rbus.io_mem_cmd_ready = 0;
        settle(); check("overrun_before", rbus.io_refreshOverrun, 0);
        for (int k = 0; k < 20; k++) begin
            if (k != 0) settle();
            tick();
        end
        settle();
        check("overrun_set", rbus.io_refreshOverrun, 1);
        check("ref_held", {rbus.io_mem_cmd_valid, rbus.io_mem_cmd_refresh}, 2'b11);
        rbus.io_mem_cmd_ready = 1;
        tick();
        for (int k = 0; k < 4; k++) begin settle(); tick(); end
        settle(); check("overrun_sticky", rbus.io_refreshOverrun, 1);
        do_reset();
        settle(); check("overrun_cleared", rbus.io_refreshOverrun, 0);
        tick();

        check("sb_cmd_drained", 64'(cmd_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 781, clock cycles between refresh requests.
REQ-004 SHALL have parameter PENDING_DEPTH, default 4, depth of the read-source FIFO (power of 2, >= 2).
REQ-005 SHALL have port io_axiClk  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 SHALL have port io_asyncReset  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports io_{cpu,vga}_cmd_valid  in  1  requester command valid.
REQ-008 SHALL have ports io_{cpu,vga}_cmd_ready  out  1  requester command accepted.
REQ-009 SHALL have ports io_{cpu,vga}_cmd_write  in  1  1 = write, 0 = read.
REQ-010 SHALL have ports io_{cpu,vga}_cmd_address  in  ADDR_WIDTH  word address.
REQ-011 SHALL have ports io_{cpu,vga}_cmd_data  in  DATA_WIDTH  write data.
REQ-012 SHALL have ports io_{cpu,vga}_rsp_valid  out  1  read data valid for that requester.
REQ-013 SHALL have ports io_{cpu,vga}_rsp_data  out  DATA_WIDTH  read data; both ports SHALL be driven from io_mem_rsp_data.
REQ-014 SHALL have port io_mem_cmd_valid  out  1  command to the SDRAM controller is valid.
REQ-015 SHALL have port io_mem_cmd_ready  in  1  the SDRAM controller accepts the command.
REQ-016 SHALL have port io_mem_cmd_refresh  out  1  1 = auto-refresh command.
REQ-017 SHALL have ports io_mem_cmd_write/address/data  out  1/ADDR_WIDTH/DATA_WIDTH  registered command payload.
REQ-018 SHALL have port io_mem_rsp_valid  in  1  read data returns in order.
REQ-019 SHALL have port io_mem_rsp_data  in  DATA_WIDTH  read data.
REQ-020 SHALL have port io_refreshOverrun  out  1  sticky flag: a refresh deadline was missed.

Function
REQ-021 SHALL implement an FSM with states IDLE, CMD and REFRESH.
REQ-022 In IDLE with refreshPending=1, SHALL load a refresh command (refresh=1, write=0, address=0, data=0), clear refreshPending, go to REFRESH, and assert no cmd_ready that cycle.
REQ-023 In IDLE otherwise, a port SHALL be eligible when cmd_valid=1 and (write=1 or FIFO occupancy < PENDING_DEPTH, where occupancy excludes any same-cycle pop).
REQ-024 The winner's cmd_ready SHALL be asserted combinationally in that cycle, its payload captured, and the FSM SHALL move to CMD; cmd_ready SHALL never be asserted outside IDLE, nor to more than one port at a time.
REQ-025 A captured read SHALL push its source (0 = cpu, 1 = vga) into the FIFO in the capture cycle.
REQ-026 In CMD or REFRESH, io_mem_cmd_valid SHALL be 1 with a stable payload; on io_mem_cmd_ready=1 the FSM SHALL return to IDLE. Port handshake at cycle N gives io_mem_cmd_valid at N+1.
REQ-027 Arbitration SHALL be round-robin: when both ports are eligible, the port not granted last SHALL win; a single eligible port SHALL always win.
REQ-028 On io_mem_rsp_valid=1 with the FIFO non-empty, the head SHALL be popped and the matching io_*_rsp_valid asserted in the same cycle; with the FIFO empty the response SHALL be dropped with no pop.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo PENDING_DEPTH.
REQ-030 A free-running down-counter SHALL count from REFRESH_CYCLES-1 to 0 and then reload; at 0 it SHALL set refreshPending; if refreshPending is already 1 at that point, it SHALL set io_refreshOverrun.

Reset
REQ-031 Asserting io_asyncReset SHALL immediately force: FSM=IDLE; all cmd_ready, rsp_valid and io_mem_cmd_valid outputs =0; payload=0; FIFO empty; counter=REFRESH_CYCLES-1; refreshPending=0; io_refreshOverrun=0; last grant=vga (so cpu wins the first tie).
REQ-032 Reset mid-operation SHALL discard any in-flight command and pending sources without issuing further commands.

Configuration
REQ-033 With macro SDRAM_ARBITER_VGA_PRIO_EN defined, vga SHALL have fixed priority over cpu; refresh SHALL remain highest priority.
REQ-034 With SDRAM_ARBITER_VGA_PRIO_EN undefined, REQ-027 round-robin SHALL apply.

Verification
REQ-035 Both ports issue continuous reads to 0x10/0x20 -> grants alternate cpu, vga, cpu; io_mem_cmd_valid 1 cycle after each cmd_ready.
REQ-036 Issue 4 vga reads with io_mem_rsp_valid held 0 -> 5th read stalls (cmd_ready=0) while a cpu write is still granted; 1 response releases 1 read.
REQ-037 Return responses 0xA5A5 then 0x5A5A for reads ordered cpu, vga -> io_cpu_rsp_valid with 0xA5A5, then io_vga_rsp_valid with 0x5A5A.
REQ-038 REFRESH_CYCLES=8, ports idle -> io_mem_cmd_refresh=1 every 8 cycles; hold io_mem_cmd_ready=0 for 20 cycles -> io_refreshOverrun=1.
REQ-039 Pulse io_asyncReset while in CMD with 2 sources pending -> io_mem_cmd_valid=0 immediately; a later io_mem_rsp_valid produces no rsp_valid.
REQ-040 With SDRAM_ARBITER_VGA_PRIO_EN defined, both ports continuously valid -> vga granted every time.
